// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter and its multdiv holding FIFO.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } gnt_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO with async active-low reset; head is visible without a read cycle.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 38
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is never reset: the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback (A) and multdiv results (B),
// buffering B in a FIFO and tracking destinations with multdiv results still outstanding.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int NREG       = 32
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  b_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_reg,
    output logic [NREG-1:0]       busy,
    output logic                  ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0]     data_writeReg
);
    wb_req_t               push_req, head;
    logic                  fifo_full, fifo_empty, push, pop;
    gnt_e                  gnt;
    logic [NREG-1:0]       set_mask, clr_mask, busy_q, busy_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;

    assign b_ready  = !fifo_full;
    assign a_ready  = !fifo_full;
    assign push     = b_valid && b_ready;
    assign push_req = '{valid: 1'b1, addr: b_reg, data: b_data};
    assign pop      = (gnt == GNT_B);

    wb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(wb_req_t))) u_fifo (
        .clk_i   (clock),
        .rst_ni  (ctrl_reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_req),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    // A full FIFO must drain first or the multdiv unit would stall indefinitely.
    always_comb begin
        gnt = GNT_IDLE;
        if (fifo_full)        gnt = GNT_B;
        else if (a_valid)     gnt = GNT_A;
        else if (!fifo_empty) gnt = GNT_B;
    end

    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (gnt == GNT_A && a_reg != '0) begin
            we_d    = 1'b1;
            wreg_d  = a_reg;
            wdata_d = a_data;
        end else if (gnt == GNT_B && head.valid && head.addr != '0) begin
            we_d    = 1'b1;
            wreg_d  = head.addr;
            wdata_d = head.data;
        end
    end

    // Set after clear so a re-issue in the drain cycle keeps the register busy.
    always_comb begin
        set_mask  = issue_valid ? (NREG'(1) << issue_reg) : '0;
        clr_mask  = pop ? (NREG'(1) << head.addr) : '0;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign busy             = busy_q;
    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates the register file's single write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg) between two sources: the in-order pipeline writeback (source A) and the long-latency multiply/divide unit (source B).
- Holds multdiv results in a 2-entry FIFO and keeps a busy scoreboard of destinations with multdiv results still outstanding, so the hazard logic can stall on them.
- Sits between the writeback stage / multdiv unit and the register file write port.

Parameters:
- FIFO_DEPTH, 2, multdiv holding FIFO entries (power of two, min 2)
- NREG, 32, number of architectural registers (write address width 5)

Ports:
- clock  input  1  rising-edge clock
- ctrl_reset_n  input  1  asynchronous active-low reset
- a_valid  input  1  pipeline writeback request
- a_reg  input  5  pipeline destination register
- a_data  input  32  pipeline writeback data
- a_ready  output  1  pipeline request accepted this cycle
- b_valid  input  1  multdiv result valid
- b_reg  input  5  multdiv destination register
- b_data  input  32  multdiv result data
- b_ready  output  1  FIFO can accept a multdiv result
- issue_valid  input  1  a multdiv op is issued this cycle
- issue_reg  input  5  destination of the issued multdiv op
- busy  output  32  per-register pending-multdiv bit
- ctrl_writeEnable  output  1  regfile write enable (registered)
- ctrl_writeReg  output  5  regfile write address (registered)
- data_writeReg  output  32  regfile write data (registered)

Behaviour:
- Reset is asynchronous on ctrl_reset_n low. Every register is cleared: FIFO empty, busy = 0, ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0.
- A write to register 0 from either source is accepted and dropped. It never asserts ctrl_writeEnable, and any busy[0] set/clear is ignored, so busy[0] is always 0.
- b_ready = !fifo_full. A B result is pushed when b_valid && b_ready. A push into an empty FIFO is not eligible for draining until the next cycle (no bypass).
- Arbitration is evaluated each cycle on the current FIFO state:
  - If the FIFO is full, B (FIFO head) wins and a_ready = 0.
  - Otherwise, if a_valid is high, A wins and a_ready = 1.
  - Otherwise, if the FIFO is not empty, B head wins.
  - Otherwise the cycle is idle.
- a_ready is combinational from the FIFO full flag only. It is independent of a_valid.
- The winner's reg/data are registered onto the write port. Latency from grant to ctrl_writeEnable is exactly 1 cycle. ctrl_writeEnable is high for one cycle per granted, nonzero write.
- On an idle cycle ctrl_writeEnable = 0 and ctrl_writeReg / data_writeReg hold their last values.
- A simultaneous push and pop while the FIFO is full is legal: the pop happens and b_ready is 0 that cycle, so no push actually occurs.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is kept in log2(FIFO_DEPTH)+1 bits.
- Scoreboard:
  - busy[issue_reg] is set on issue_valid.
  - busy[r] is cleared on the cycle B's entry for r is granted.
  - Set and clear of the same register in the same cycle: set wins, because a new op is outstanding.
  - A second issue to a register that is already busy is illegal upstream. Behaviour is only defined as "stays set".
- A write from A to a register whose busy bit is set is allowed and does not change busy. Ordering is upstream's responsibility.
- Reset mid-operation discards all FIFO contents and busy bits. A write granted in the cycle reset asserts does not reach the port.

Decomposition:
- Shared package holds:
  - REG_ADDR_W = 5
  - DATA_W = 32
  - the wb_req struct (valid, reg, data)
  - the arbitration grant enum: GNT_IDLE, GNT_A, GNT_B
- One natural sub-module: wb_fifo, a synchronous FIFO with async active-low reset, providing push, pop, full, empty and head. It is reusable by the multdiv unit.
- The 5-to-32 one-hot decode for busy set/clear stays inline.

Test Plan:
- Reset and idle:
  - Stimulus: hold ctrl_reset_n low with random inputs, then release with all inputs idle.
  - Required: all outputs 0, b_ready = 1, a_ready = 1, and ctrl_writeEnable stays 0 for 10 cycles.
- A only:
  - Stimulus: a_valid with reg=5, data=0xDEADBEEF in cycle N.
  - Required: in cycle N+1, ctrl_writeEnable = 1, ctrl_writeReg = 5, data_writeReg = 0xDEADBEEF. In cycle N+2, ctrl_writeEnable = 0.
- Register 0 dropped:
  - Stimulus: A write to reg 0, then B result to reg 0 with issue_reg = 0.
  - Required: ctrl_writeEnable never asserts, busy[0] stays 0, and both handshakes complete.
- Contention:
  - Stimulus: issue to reg 7; b_valid with reg=7, data=0x11 in cycle N; a_valid continuously from cycle N onward.
  - Required: A is granted every cycle while the FIFO is not full. The B write appears only once the FIFO fills or A goes idle. busy[7] goes 1→0 in the cycle after B is granted.
- FIFO full:
  - Stimulus: three back-to-back B results with a_valid held high.
  - Required: after two pushes b_ready = 0 and a_ready = 0, and B entries drain in order. The third result is accepted once b_ready returns to 1, and no data is lost or reordered.
- Scoreboard same-cycle conflict and reset:
  - Stimulus: issue reg 9 in the same cycle B's reg-9 entry is granted, then assert reset while the FIFO holds 2 entries.
  - Required: busy[9] remains 1 after the conflict cycle. The FIFO empties and busy = 0 immediately on reset, with no write after it.
